dsm_decimator: RTL and testbench

Receive-side counterpart of the delta-sigma transmit chain. Takes a 1-bit delta-sigma bitstream over AXI-Stream and reconstructs multi-bit samples with an ORDER-stage CIC decimator. The decimation ratio is 2^DEC_LOG2. Output samples are unsigned offset-binary WIDTH-bit words on AXI-Stream with backpressure, in the same format the NCOs produce. It sits behind a bitstream capture/loopback path for on-chip verification of the modulator output.

---
 rtl/dsm_decimator.sv | 106 ++++++++++
 tb/tb_dsm_decimator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/dsm_decimator.sv
// dsm_decimator: rebuilds WIDTH-bit offset-binary samples from a 1-bit delta-sigma stream with an ORDER-stage CIC, R = 2^DEC_LOG2.
// Optional macro DSM_DECIMATOR_WARMUP_EN hides the first ORDER samples after reset (CIC start-up transient).
module dsm_decimator #(
  parameter int WIDTH    = 16,
  parameter int ORDER    = 3,
  parameter int DEC_LOG2 = 4
) (
  input  logic             aclk,
  input  logic             arst_n,
  input  logic             s_axis_data_tdata,
  input  logic             s_axis_data_tvalid,
  output logic             s_axis_data_tready,
  output logic [WIDTH-1:0] m_axis_data_tdata,
  output logic             m_axis_data_tvalid,
  input  logic             m_axis_data_tready
);
  localparam int ACC_W = ORDER*DEC_LOG2+2;
  localparam int U_W   = ORDER*DEC_LOG2+1;
  localparam logic [DEC_LOG2-1:0] PH_LAST = {DEC_LOG2{1'b1}};

  logic [DEC_LOG2-1:0]         phase;
  logic                        strobe;
  logic [ORDER-1:0][ACC_W-1:0] integ, integ_nxt, dly;
  logic [ORDER:0][ACC_W-1:0]   comb_v;
  logic [ACC_W-1:0]            x;
  logic signed [ACC_W:0]       u_full;
  logic [U_W-1:0]              u_c;
  logic [WIDTH-1:0]            samp;
  logic                        xfer_in, show;

  // Only the frame-completing bit stalls, so a pending sample is never overwritten.
  assign s_axis_data_tready = !((phase == PH_LAST) &&
                                (strobe || (m_axis_data_tvalid && !m_axis_data_tready)));
  assign xfer_in = s_axis_data_tvalid && s_axis_data_tready;
  assign x       = s_axis_data_tdata ? ACC_W'(1) : {ACC_W{1'b1}};

  // Integrator cascade feeds each stage the freshly updated value of the previous one.
  always_comb begin
    integ_nxt[0] = integ[0] + x;
    for (int k = 1; k < ORDER; k++) integ_nxt[k] = integ[k] + integ_nxt[k-1];
  end

  always_comb begin
    comb_v[0] = integ[ORDER-1];
    for (int k = 0; k < ORDER; k++) comb_v[k+1] = comb_v[k] - dly[k];
  end

  // Offset by R^ORDER to make the comb output unsigned, then clamp to U_W bits.
  assign u_full = $signed({comb_v[ORDER][ACC_W-1], comb_v[ORDER]}) +
                  $signed({3'b001, {(U_W-1){1'b0}}});

  always_comb begin
    if (u_full[ACC_W])        u_c = '0;
    else if (u_full[ACC_W-1]) u_c = '1;
    else                      u_c = u_full[U_W-1:0];
  end

  generate
    if (WIDTH <= U_W) begin : g_trunc
      assign samp = u_c[U_W-1 -: WIDTH];
    end else begin : g_shift
      assign samp = {u_c, {(WIDTH-U_W){1'b0}}};
    end
  endgenerate

`ifdef DSM_DECIMATOR_WARMUP_EN
  localparam int WARM_W = $clog2(ORDER+1);
  localparam logic [WARM_W-1:0] WARM_DONE = WARM_W'(ORDER);
  logic [WARM_W-1:0] warm;

  assign show = (warm == WARM_DONE);

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n)              warm <= '0;
    else if (strobe && !show) warm <= warm + 1'b1;
  end
`else
  assign show = 1'b1;
`endif

  always_ff @(posedge aclk or negedge arst_n) begin
    if (!arst_n) begin
      phase              <= '0;
      strobe             <= 1'b0;
      integ              <= '0;
      dly                <= '0;
      m_axis_data_tvalid <= 1'b0;
      m_axis_data_tdata  <= '0;
    end else begin
      strobe <= xfer_in && (phase == PH_LAST);
      if (xfer_in) begin
        integ <= integ_nxt;
        phase <= phase + 1'b1;
      end
      if (strobe) begin
        for (int k = 0; k < ORDER; k++) dly[k] <= comb_v[k];
      end
      if (strobe && show) begin
        m_axis_data_tdata  <= samp;
        m_axis_data_tvalid <= 1'b1;
      end else if (m_axis_data_tvalid && m_axis_data_tready) begin
        m_axis_data_tvalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dsm_decimator.sv
// Bench for dsm_decimator at default parameters: directed table, hand sequences, random traffic vs a binomial CIC model.
module tb_dsm_decimator;
  localparam int ORDER = 3;
  localparam int R     = 16;
`ifdef DSM_DECIMATOR_WARMUP_EN
  localparam int WARM = ORDER;
`else
  localparam int WARM = 0;
`endif
  localparam logic       FIRST_VLD = (WARM == 0);
  localparam logic [15:0] FIRST_DAT = (WARM == 0) ? 16'h9980 : 16'h0000;

  logic        aclk = 1'b0, arst_n = 1'b0;
  logic        s_tdata = 1'b0, s_tvalid = 1'b0, s_tready;
  logic [15:0] m_tdata;
  logic        m_tvalid, m_tready = 1'b0;

  int n_cmp = 0, n_bad = 0;

  bit          bits[$];
  logic [15:0] expq[$];
  int          warm_skip;
  int          seg_outs;
  bit          cen;
  int          cfrom;
  logic [15:0] cval;
  bit          last_hold;
  logic [15:0] last_data;

  typedef struct {
    bit d, v, r;
    bit e_rdy, e_vld;
    logic [15:0] e_dat;
  } vec_t;
  vec_t tbl[18];

  always #5 aclk = ~aclk;

  dsm_decimator dut (
    .aclk(aclk), .arst_n(arst_n),
    .s_axis_data_tdata(s_tdata), .s_axis_data_tvalid(s_tvalid), .s_axis_data_tready(s_tready),
    .m_axis_data_tdata(m_tdata), .m_axis_data_tvalid(m_tvalid), .m_axis_data_tready(m_tready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic longint binom(input longint n, input int k);
    longint r = 1;
    if (n < k) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Last integrator after nb bits: each bit weighted by C(age+ORDER-1, ORDER-1).
  function automatic longint integ_at(input int nb);
    longint s = 0;
    for (int j = 0; j < nb; j++)
      s += (bits[j] ? 1 : -1) * binom(nb - 1 - j + ORDER - 1, ORDER - 1);
    return s;
  endfunction

  // ORDER-th difference of the decimated integrator sequence, wrapped, offset, clamped, scaled.
  function automatic logic [15:0] model_sample();
    int     m = bits.size() / R;
    longint y = 0;
    longint u;
    for (int i = 0; i <= ORDER; i++)
      if (m - i > 0) y += ((i % 2) ? -1 : 1) * binom(ORDER, i) * integ_at((m - i) * R);
    y = ((y % 16384) + 16384) % 16384;
    if (y >= 8192) y -= 16384;
    u = y + 4096;
    if (u < 0) u = 0;
    if (u > 8191) u = 8191;
    return 16'(u * 8);
  endfunction

  task automatic cycle(input bit d, input bit v, input bit r);
    bit acc, ox;
    s_tdata = d; s_tvalid = v; m_tready = r;
    #2;
    acc = v && s_tready;
    ox  = m_tvalid && r;
    if (!s_tready) chk("stall_phase", 32'(bits.size() % R), R - 1);
    if (last_hold) begin
      chk("hold_valid", m_tvalid, 1);
      chk("hold_data", m_tdata, last_data);
    end
    last_hold = m_tvalid && !r;
    last_data = m_tdata;
    if (ox) begin
      chk("out_expected", expq.size() != 0, 1);
      if (expq.size() != 0) chk("sample", m_tdata, expq.pop_front());
      if (cen && seg_outs >= cfrom) chk("steady", m_tdata, cval);
      seg_outs++;
    end
    if (acc) begin
      bits.push_back(d);
      if (bits.size() % R == 0) begin
        if (warm_skip > 0) warm_skip--;
        else expq.push_back(model_sample());
      end
    end
    @(posedge aclk); #1;
  endtask

  task automatic do_reset();
    arst_n = 1'b0; s_tvalid = 1'b0; m_tready = 1'b0;
    #1;
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_tready", s_tready, 1);
    @(posedge aclk); #1;
    arst_n = 1'b1;
    bits.delete(); expq.delete();
    warm_skip = WARM; seg_outs = 0; last_hold = 0; cen = 0;
  endtask

  task automatic drain();
    repeat (4) cycle(0, 0, 1);
    chk("all_delivered", expq.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) tbl[i] = '{1, 1, 1, 1, 0, 16'h0};
    tbl[16] = '{0, 0, 0, 1, FIRST_VLD, FIRST_DAT};
    tbl[17] = '{0, 0, 1, 1, 0, 16'h0};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(tbl[i].d, tbl[i].v, tbl[i].r);
      chk($sformatf("tbl%0d_rdy", i), s_tready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_vld", i), m_tvalid, tbl[i].e_vld);
      if (tbl[i].e_vld) chk($sformatf("tbl%0d_dat", i), m_tdata, tbl[i].e_dat);
    end
    drain();

    // all ones: saturates at the clamped full scale
    do_reset(); cen = 1; cval = 16'hFFF8; cfrom = 3 - WARM;
    repeat (16 * 7) cycle(1, 1, 1);
    drain();
    chk("ones_count", seg_outs, 7 - WARM);

    do_reset(); cen = 1; cval = 16'h0000; cfrom = 3 - WARM;
    repeat (16 * 6) cycle(0, 0, 0) ;
    repeat (16 * 6) cycle(0, 1, 1);
    drain();
    chk("zeros_count", seg_outs, 6 - WARM);

    do_reset(); cen = 1; cval = 16'h8000; cfrom = 3 - WARM;
    for (int i = 0; i < 16 * 6; i++) cycle(i % 2 == 0, 1, 1);
    drain();
    chk("alt_count", seg_outs, 6 - WARM);

    // downstream stalled for 40 cycles with input always offered
    do_reset();
    repeat (40) cycle(1, 1, 0);
    chk("bp_stalled", s_tready, (WARM > 0) ? 1 : 0);
    repeat (16 * 4) cycle(1, 1, 1);
    drain();

    // reset mid-frame at phase 9 with a sample pending
    do_reset();
    repeat (25) cycle(1, 1, 0);
    chk("pend_vld", m_tvalid, FIRST_VLD);
    chk("pend_phase", 32'(bits.size() % R), 9);
    do_reset();
    repeat (15) cycle(1, 1, 1);
    repeat (3) cycle(0, 0, 1);
    chk("no_early_out", m_tvalid, 0);
    cycle(1, 1, 1);
    chk("strobe_cycle_vld", m_tvalid, 0);
    cycle(0, 0, 1);
    chk("post_rst_first_vld", m_tvalid, FIRST_VLD);
    drain();

    do_reset();
    repeat (1500) cycle($urandom % 2, ($urandom % 4) != 0, ($urandom % 3) != 0);
    drain();
    do_reset();
    repeat (800) cycle($urandom % 2, ($urandom % 5) != 0, ($urandom % 5) == 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
